// File: rtl/pe_pkg.sv
`default_nettype none
// ===================================================================
// pe_pkg : shared types and constants for the 3-tap conv PE feeder
// Rev 1.0
// ===================================================================
package pe_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } feeder_state_t;

  // Select vector order: {sel_m0, sel_m1, sel_m2, sel_m3, sel1, sel0}
  localparam logic [5:0] SEL_FIRST  = 6'b000000;
  localparam logic [5:0] SEL_STEADY = 6'b011110;

  typedef struct packed {
    logic [2*N_DEFAULT-1:0] data;
    logic                   last;
  } res_t;

endpackage
`default_nettype wire

// File: rtl/pe_res_fifo.sv
`default_nettype none
// ===================================================================
// pe_res_fifo : synchronous result FIFO, same-cycle push+pop allowed
// Rev 1.0
// ===================================================================
module pe_res_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pe_feeder.sv
`default_nettype none
// ===================================================================
// pe_feeder : sequencer/collector for the 3-tap 1-D conv PE.
// Optional FEEDER_PERF_EN adds the stall_cnt output.  Rev 1.0
// ===================================================================
module pe_feeder
  import pe_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int LEN_W      = 8,
  parameter int PE_LAT     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] row_len,
  input  logic [N-1:0]     w0,
  input  logic [N-1:0]     w1,
  input  logic [N-1:0]     w2,
  input  logic             act_valid,
  output logic             act_ready,
  input  logic [N-1:0]     act_data,
  output logic [N-1:0]     pe_i0,
  output logic [N-1:0]     pe_i1,
  output logic [N-1:0]     pe_w0,
  output logic [N-1:0]     pe_w1,
  output logic [N-1:0]     pe_w2,
  output logic             pe_sel_m0,
  output logic             pe_sel_m1,
  output logic             pe_sel_m2,
  output logic             pe_sel_m3,
  output logic             pe_sel0,
  output logic             pe_sel1,
  output logic             pe_rst_n,
  input  logic [2*N-1:0]   pe_out1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*N-1:0]   res_data,
  output logic             res_last,
  output logic             busy,
`ifdef FEEDER_PERF_EN
  output logic [31:0]      stall_cnt,
`endif
  output logic             err_len
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = 2 * N + 1;

  feeder_state_t     state_q, state_d;
  logic [LEN_W-1:0]  row_len_q, row_len_d, beat_q, beat_d;
  logic [PE_LAT-1:0] tag_q, tag_d, last_q, last_d;
  logic [N-1:0]      pe_i0_q, pe_i0_d, pe_i1_q, pe_i1_d;
  logic [N-1:0]      pe_w0_q, pe_w0_d, pe_w1_q, pe_w1_d, pe_w2_q, pe_w2_d;
  logic [5:0]        sel_q, sel_d;
  logic              pe_rst_n_q, pe_rst_n_d, err_len_q, err_len_d;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [EW-1:0]     fifo_head;
  logic              credit_ok, issue, tag_in, is_last_beat;

  // Every beat that will produce a result reserves a FIFO slot up front.
  assign credit_ok    = (int'(fifo_count) + $countones(tag_q)) < FIFO_DEPTH;
  assign act_ready    = (state_q == S_STREAM) && credit_ok;
  assign issue        = act_valid && act_ready;
  assign is_last_beat = (beat_q == (row_len_q - LEN_W'(1)));
  assign tag_in       = issue && (beat_q >= LEN_W'(2));

  always_comb begin
    state_d   = state_q;
    row_len_d = row_len_q;
    beat_d    = beat_q;
    pe_i0_d   = pe_i0_q;
    pe_i1_d   = pe_i1_q;
    pe_w0_d   = pe_w0_q;
    pe_w1_d   = pe_w1_q;
    pe_w2_d   = pe_w2_q;
    sel_d     = sel_q;
    err_len_d = err_len_q;
    tag_d     = (tag_q << 1) | PE_LAT'(tag_in);
    last_d    = (last_q << 1) | PE_LAT'(tag_in && is_last_beat);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (row_len >= LEN_W'(3)) begin
            row_len_d = row_len;
            pe_w0_d   = w0;
            pe_w1_d   = w1;
            pe_w2_d   = w2;
            beat_d    = '0;
            err_len_d = 1'b0;
            state_d   = S_CLEAR;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      S_CLEAR: state_d = S_STREAM;
      S_STREAM: begin
        if (issue) begin
          pe_i1_d = act_data;
          pe_i0_d = pe_i1_q;
          sel_d   = (beat_q == LEN_W'(0)) ? SEL_FIRST : SEL_STEADY;
          beat_d  = beat_q + LEN_W'(1);
          if (is_last_beat) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (tag_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    pe_rst_n_d = (state_d != S_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      row_len_q  <= '0;
      beat_q     <= '0;
      tag_q      <= '0;
      last_q     <= '0;
      pe_i0_q    <= '0;
      pe_i1_q    <= '0;
      pe_w0_q    <= '0;
      pe_w1_q    <= '0;
      pe_w2_q    <= '0;
      sel_q      <= '0;
      pe_rst_n_q <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_len_q  <= row_len_d;
      beat_q     <= beat_d;
      tag_q      <= tag_d;
      last_q     <= last_d;
      pe_i0_q    <= pe_i0_d;
      pe_i1_q    <= pe_i1_d;
      pe_w0_q    <= pe_w0_d;
      pe_w1_q    <= pe_w1_d;
      pe_w2_q    <= pe_w2_d;
      sel_q      <= sel_d;
      pe_rst_n_q <= pe_rst_n_d;
      err_len_q  <= err_len_d;
    end
  end

  // The oldest tag leaving the pipe marks the cycle its result sits on pe_out1.
  pe_res_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_res_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (tag_q[PE_LAT-1]),
    .push_data ({last_q[PE_LAT-1], pe_out1}),
    .pop       (res_valid && res_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign res_valid = !fifo_empty;
  assign res_data  = fifo_empty ? '0 : fifo_head[2*N-1:0];
  assign res_last  = !fifo_empty && fifo_head[2*N];
  assign busy      = (state_q != S_IDLE);
  assign err_len   = err_len_q;
  assign pe_i0     = pe_i0_q;
  assign pe_i1     = pe_i1_q;
  assign pe_w0     = pe_w0_q;
  assign pe_w1     = pe_w1_q;
  assign pe_w2     = pe_w2_q;
  assign pe_rst_n  = pe_rst_n_q;
  assign {pe_sel_m0, pe_sel_m1, pe_sel_m2, pe_sel_m3, pe_sel1, pe_sel0} = sel_q;

`ifdef FEEDER_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_IDLE) && start) begin
      stall_cnt_d = '0;
    end else if ((state_q == S_STREAM) && act_valid && !act_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_feeder.sv
`default_nettype none
// Bench for pe_feeder: random rows through a behavioural 3-tap PE, results
// compared with windows computed directly from the applied activations.
module tb_pe_feeder;

  localparam int N = 8, LEN_W = 8, PE_LAT = 3, FIFO_DEPTH = 4;
  localparam logic [5:0] STEADY = 6'b011110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, start, act_valid, res_ready;
  logic [LEN_W-1:0] row_len;
  logic [N-1:0]     w0, w1, w2, act_data;
  logic [2*N-1:0]   pe_out1;
  logic             act_ready, pe_rst_n, res_valid, res_last, busy, err_len;
  logic [N-1:0]     pe_i0, pe_i1, pe_w0, pe_w1, pe_w2;
  logic             pe_sel_m0, pe_sel_m1, pe_sel_m2, pe_sel_m3, pe_sel0, pe_sel1;
  logic [2*N-1:0]   res_data;
`ifdef FEEDER_PERF_EN
  logic [31:0]      stall_cnt;
`endif

  pe_feeder #(.N(N), .LEN_W(LEN_W), .PE_LAT(PE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .row_len(row_len),
    .w0(w0), .w1(w1), .w2(w2),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .pe_i0(pe_i0), .pe_i1(pe_i1), .pe_w0(pe_w0), .pe_w1(pe_w1), .pe_w2(pe_w2),
    .pe_sel_m0(pe_sel_m0), .pe_sel_m1(pe_sel_m1), .pe_sel_m2(pe_sel_m2), .pe_sel_m3(pe_sel_m3),
    .pe_sel0(pe_sel0), .pe_sel1(pe_sel1), .pe_rst_n(pe_rst_n), .pe_out1(pe_out1),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy),
`ifdef FEEDER_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .err_len(err_len)
  );

  int n_vec = 0, n_err = 0;
  int cyc = 0, issued = 0, clear_pulses = 0;
  logic [N-1:0]   src[$];
  logic [2*N:0]   got_q[$];
  logic [N-1:0]   rw0, rw1, rw2;
  logic [N-1:0]   pe_x2;
  logic [2*N-1:0] pe_p1, pe_p2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [5:0] sels();
    return {pe_sel_m0, pe_sel_m1, pe_sel_m2, pe_sel_m3, pe_sel1, pe_sel0};
  endfunction

  // Golden PE: a 3-tap window over {oldest, pe_i0, pe_i1}, two output stages.
  function automatic logic [2*N-1:0] pe_y();
    int s;
    if (sels() != STEADY) return '0;
    s = int'(pe_w0) * int'(pe_x2) + int'(pe_w1) * int'(pe_i0) + int'(pe_w2) * int'(pe_i1);
    return s[2*N-1:0];
  endfunction

  task automatic tick();
    logic           iss, pop, rst_edge, pbusy;
    logic [N-1:0]   pi0, pi1, ad, x2n;
    logic [5:0]     ps;
    logic [2*N-1:0] p1n, p2n;
    iss      = reset_n && act_valid && act_ready;
    pop      = reset_n && res_valid && res_ready;
    rst_edge = !reset_n;
    pbusy    = busy;
    pi0 = pe_i0; pi1 = pe_i1; ps = sels(); ad = act_data;
    if (pop) got_q.push_back({res_last, res_data});
    if (iss) issued++;
    if (reset_n && busy && !pe_rst_n) clear_pulses++;
    if (!pe_rst_n) begin
      x2n = '0; p1n = '0; p2n = '0;
    end else begin
      p2n = pe_p1;
      p1n = pe_y();
      x2n = iss ? pe_i0 : pe_x2;
    end
    @(posedge clk); #1;
    pe_x2 = x2n; pe_p1 = p1n; pe_p2 = p2n; pe_out1 = p2n;
    cyc++;
    if (!rst_edge && pbusy) begin
      if (iss) begin
        chk("pe_i1_load", 32'(pe_i1), 32'(ad));
        chk("pe_i0_shift", 32'(pe_i0), 32'(pi1));
        chk("pe_sel", 32'(sels()), (issued == 1) ? 32'd0 : 32'(STEADY));
      end else begin
        chk("pe_hold", 32'({pe_i0, pe_i1, sels()}), 32'({pi0, pi1, ps}));
      end
    end
  endtask

  task automatic fill_random(input int len);
    src.delete();
    for (int i = 0; i < len; i++) src.push_back(N'($urandom_range(255)));
  endtask

  task automatic start_row(input int len, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] c);
    issued = 0; clear_pulses = 0; got_q.delete();
    rw0 = a; rw1 = b; rw2 = c;
    row_len = LEN_W'(len); w0 = a; w1 = b; w2 = c;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic feed_drain(input int len, input int vpct, input int rpct, input bit toggle);
    int c = 0;
    while (c < 3000 && (issued < len || busy || res_valid)) begin
      act_valid = (issued < len) && (toggle ? cyc[0] : ($urandom_range(99) < vpct));
      act_data  = (issued < len) ? src[issued] : '0;
      res_ready = ($urandom_range(99) < rpct);
      tick();
      c++;
    end
    act_valid = 1'b0;
  endtask

  task automatic check_row(input int len, input string tag);
    chk({tag, "_issued"}, issued, len);
    chk({tag, "_count"}, got_q.size(), len - 2);
    for (int j = 0; j < len - 2 && j < got_q.size(); j++) begin
      int s;
      s = int'(rw0) * int'(src[j]) + int'(rw1) * int'(src[j+1]) + int'(rw2) * int'(src[j+2]);
      chk({tag, "_data"}, 32'(got_q[j][2*N-1:0]), 32'(s[2*N-1:0]));
      chk({tag, "_last"}, 32'(got_q[j][2*N]), (j == len - 3) ? 32'd1 : 32'd0);
    end
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_clear"}, clear_pulses, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_act_ready"}, 32'(act_ready), 0);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_res_last"}, 32'(res_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err_len"}, 32'(err_len), 0);
    chk({tag, "_pe_data"}, 32'({pe_i0, pe_i1, pe_w0}), 0);
    chk({tag, "_pe_w12"}, 32'({pe_w1, pe_w2}), 0);
    chk({tag, "_sels"}, 32'(sels()), 0);
    chk({tag, "_pe_rst_n"}, 32'(pe_rst_n), 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; row_len = '0; w0 = '0; w1 = '0; w2 = '0;
    act_valid = 1'b0; act_data = '0; res_ready = 1'b0; pe_out1 = '0;
    pe_x2 = '0; pe_p1 = '0; pe_p2 = '0;
    repeat (3) tick();
    check_reset_vals("reset");
    reset_n = 1'b1;
    tick();

    // Basic row: 1*1+2*2+3*3 = 14, 1*2+2*3+3*4 = 20
    src = '{8'd1, 8'd2, 8'd3, 8'd4};
    start_row(4, 8'd1, 8'd2, 8'd3);
    feed_drain(4, 100, 100, 1'b0);
    check_row(4, "basic");

    // Backpressure: credit admits beats 0,1 plus FIFO_DEPTH result beats.
    fill_random(8);
    start_row(8, N'($urandom_range(255)), N'($urandom_range(255)), N'($urandom_range(255)));
    res_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      act_valid = (issued < 8);
      act_data  = (issued < 8) ? src[issued] : '0;
      tick();
    end
    chk("bp_issued", issued, 2 + FIFO_DEPTH);
    chk("bp_act_ready", 32'(act_ready), 0);
    chk("bp_res_valid", 32'(res_valid), 1);
    chk("bp_no_pop", got_q.size(), 0);
    feed_drain(8, 100, 100, 1'b0);
    check_row(8, "bp");

    // Bubbles: alternating act_valid gives the same results as the basic row.
    src = '{8'd1, 8'd2, 8'd3, 8'd4};
    start_row(4, 8'd1, 8'd2, 8'd3);
    feed_drain(4, 100, 100, 1'b1);
    check_row(4, "bubble");

    // Short row rejected, then a minimal row clears the error.
    row_len = LEN_W'(2); start = 1'b1; tick(); start = 1'b0;
    act_valid = 1'b1; res_ready = 1'b1;
    repeat (4) tick();
    act_valid = 1'b0;
    chk("short_err", 32'(err_len), 1);
    chk("short_busy", 32'(busy), 0);
    chk("short_act_ready", 32'(act_ready), 0);
    chk("short_res_valid", 32'(res_valid), 0);
    fill_random(3);
    start_row(3, N'($urandom_range(255)), N'($urandom_range(255)), N'($urandom_range(255)));
    chk("short_err_clr", 32'(err_len), 0);
    feed_drain(3, 100, 100, 1'b0);
    check_row(3, "len3");

    // Mid-row reset after beat 2 abandons the row.
    fill_random(6);
    start_row(6, N'($urandom_range(255)), N'($urandom_range(255)), N'($urandom_range(255)));
    res_ready = 1'b1;
    for (int i = 0; i < 20 && issued < 3; i++) begin
      act_valid = 1'b1; act_data = src[issued];
      tick();
    end
    act_valid = 1'b0;
    reset_n = 1'b0; tick();
    check_reset_vals("midrst");
    reset_n = 1'b1;
    got_q.delete();
    repeat (6) tick();
    chk("midrst_no_res", got_q.size(), 0);
    chk("midrst_res_valid", 32'(res_valid), 0);
    fill_random(5);
    start_row(5, N'($urandom_range(255)), N'($urandom_range(255)), N'($urandom_range(255)));
    feed_drain(5, 100, 100, 1'b0);
    check_row(5, "after_rst");

    // Random rows with random valid/ready duty cycles.
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(3, 12);
      fill_random(len);
      start_row(len, N'($urandom_range(255)), N'($urandom_range(255)), N'($urandom_range(255)));
      feed_drain(len, $urandom_range(30, 100), $urandom_range(30, 100), 1'b0);
      check_row(len, "rand");
    end

`ifdef FEEDER_PERF_EN
    fill_random(8);
    start_row(8, N'($urandom_range(255)), N'($urandom_range(255)), N'($urandom_range(255)));
    res_ready = 1'b0;
    for (int i = 0; i < 50 && issued < 6; i++) begin
      act_valid = act_ready; act_data = src[issued];
      tick();
    end
    act_valid = 1'b1; act_data = src[issued];
    repeat (5) tick();
    act_valid = 1'b0;
    chk("perf_stalled", 32'(act_ready), 0);
    tick();
    chk("perf_stall_cnt", stall_cnt, 5);
    feed_drain(8, 100, 100, 1'b0);
    check_row(8, "perf");
    row_len = LEN_W'(2); start = 1'b1; tick(); start = 1'b0;
    chk("perf_start_clr", stall_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
